regfile_dual_wr: RTL and testbench
==================================

Name: regfile_dual_wr

Overview:
- Parametrised successor to the pipeline register file.
- Provides 2 combinational read ports and 2 synchronous write ports (A and B; port B used for late/WB-2 writes).
- Register 0 is hard-wired to zero.
- Reads see a same-cycle write (write-first bypass).
- After reset, a sequential init sweep loads the array instead of a one-shot reset loop.

Parameters:
- DWIDTH, 32, data width in bits.
- AWIDTH, 5, address width; depth = 2**AWIDTH.
- INIT_MODE, 1, init sweep value: 0 = all zeros, 1 = entry i loaded with i (zero-extended/truncated to DWIDTH).
- ZERO_REG, 1, 1 = address 0 reads 0 and ignores writes; 0 = address 0 is an ordinary register.

Ports:
- r_clk  input  1  clock; all state changes on the rising edge.
- r_rst  input  1  reset; asynchronous assert, active-low.
- r_wr_en_a  input  1  write enable, port A.
- r_addr_in_a  input  AWIDTH  write address, port A.
- r_data_in_a  input  DWIDTH  write data, port A.
- r_wr_en_b  input  1  write enable, port B.
- r_addr_in_b  input  AWIDTH  write address, port B.
- r_data_in_b  input  DWIDTH  write data, port B.
- r_addr_out1  input  AWIDTH  read address, port 1.
- r_addr_out2  input  AWIDTH  read address, port 2.
- r_data_out1  output  DWIDTH  read data, port 1 (combinational).
- r_data_out2  output  DWIDTH  read data, port 2 (combinational).
- r_ready  output  1  1 = init sweep done, file usable.
- r_wr_conflict  output  1  registered 1-cycle pulse: both ports wrote the same effective address.

Behaviour:
- Clock is r_clk. Reset r_rst is asynchronous, active-low.
- Reset values: FSM = INIT, sweep counter = 0, r_ready = 0, r_wr_conflict = 0.
- Array contents are NOT cleared asynchronously; only the sweep writes them.
- FSM states:
  - INIT: each cycle writes data_reg[cnt] <= init value (per INIT_MODE), then cnt <= cnt+1.
  - On the cycle cnt == 2**AWIDTH-1: write the last entry, go to RUN, set r_ready = 1 at that edge.
  - The sweep takes exactly 2**AWIDTH cycles after reset release.
  - RUN: normal operation; stays until the next reset.
- Reset asserted mid-INIT or mid-RUN: immediately returns to INIT with cnt = 0 and r_ready = 0. The sweep restarts from entry 0.
- In INIT:
  - r_wr_en_a/r_wr_en_b are ignored (no array write, no bypass).
  - r_data_out1/2 = 0.
  - r_wr_conflict stays 0.
- Write (RUN only):
  - Rising edge; port A writes if r_wr_en_a, port B writes if r_wr_en_b.
  - Both enabled to the same address: port B data is stored (B wins).
  - With ZERO_REG=1, writes to address 0 are dropped by both ports.
- Read (RUN, combinational), for each read port, in priority order:
  1. ZERO_REG=1 and addr == 0 -> 0.
  2. r_wr_en_b and r_addr_in_b == addr -> r_data_in_b.
  3. r_wr_en_a and r_addr_in_a == addr -> r_data_in_a.
  4. Otherwise data_reg[addr].
  - The bypass gives zero-latency forwarding of the same-cycle write. Array update latency is 1 edge.
- Conflict flag:
  - r_wr_conflict <= r_wr_en_a & r_wr_en_b & (r_addr_in_a == r_addr_in_b) & !(ZERO_REG && addr == 0), registered.
  - High for exactly the cycle after the conflict. Informational only, no stall.
- Width rules:
  - INIT_MODE=1 value is cnt zero-extended to DWIDTH, or truncated to the low DWIDTH bits if AWIDTH > DWIDTH.
  - No arithmetic beyond the counter. The counter is AWIDTH+1 bits wide or terminates on the all-ones compare; it must not wrap into a second sweep.
- Both read ports may address the same entry; both return identical data.

Test Plan:
- Release reset, idle, DWIDTH=32 AWIDTH=5 INIT_MODE=1 -> r_ready rises exactly 32 cycles after release.
  - Afterwards, r_addr_out1=7 -> 7; r_addr_out2=31 -> 31; address 0 -> 0.
  - Before r_ready, both outputs are 0.
- RUN, write A addr 5 data 0xDEADBEEF with r_addr_out1=5 in the same cycle -> r_data_out1 = 0xDEADBEEF combinationally.
  - After the edge, with enable dropped, it still reads 0xDEADBEEF.
- Write A addr 9 = 0x11, write B addr 9 = 0x22 in the same cycle:
  - r_data_out2 (addr 9) = 0x22 during the cycle and after the edge.
  - r_wr_conflict = 1 for the one following cycle only.
- Write A addr 0 = 0xFFFFFFFF (ZERO_REG=1) -> r_data_out1 (addr 0) = 0 during and after; r_wr_conflict stays 0 even if B also writes addr 0.
- Assert r_rst low for 1 cycle after 10 sweep cycles, then release -> r_ready = 0 immediately; it rises 32 cycles after the second release; entry 3 reads 3.
- During INIT, pulse r_wr_en_a addr 4 = 0xABCD -> ignored; after r_ready, addr 4 reads 4.

Source files
------------

// File: rtl/regfile_dual_wr.sv
// Register file with two combinational read ports and two synchronous write
// ports. Port B has priority over port A when both write the same entry.
// Reads see a write made in the same cycle. After reset, a sequential sweep
// loads every entry, and r_ready goes high when the sweep is complete.
module regfile_dual_wr #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int INIT_MODE = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_wr_en_a,
  input  logic [AWIDTH-1:0] r_addr_in_a,
  input  logic [DWIDTH-1:0] r_data_in_a,
  input  logic              r_wr_en_b,
  input  logic [AWIDTH-1:0] r_addr_in_b,
  input  logic [DWIDTH-1:0] r_data_in_b,
  input  logic [AWIDTH-1:0] r_addr_out1,
  input  logic [AWIDTH-1:0] r_addr_out2,
  output logic [DWIDTH-1:0] r_data_out1,
  output logic [DWIDTH-1:0] r_data_out2,
  output logic              r_ready,
  output logic              r_wr_conflict
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              ready_q;
  logic              conflict_q;
  logic [DWIDTH-1:0] data_reg [DEPTH];

  // A write to address 0 is discarded when address 0 is hard-wired to zero.
  logic zero_a, zero_b;
  logic wr_a_ok, wr_b_ok;
  logic conflict_d;
  logic [DWIDTH-1:0] init_val;

  assign zero_a  = (ZERO_REG != 0) && (r_addr_in_a == '0);
  assign zero_b  = (ZERO_REG != 0) && (r_addr_in_b == '0);
  assign wr_a_ok = (state_q == ST_RUN) && r_wr_en_a && !zero_a;
  assign wr_b_ok = (state_q == ST_RUN) && r_wr_en_b && !zero_b;

  // The sweep value is the counter zero-extended or truncated to DWIDTH, or all zeros.
  // NOTE: every variable assigned in always_comb gets a default value first,
  // so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    init_val = '0;
    if (INIT_MODE == 1) begin
      for (int i = 0; i < DWIDTH && i < AWIDTH; i++) init_val[i] = cnt_q[i];
    end
  end

  // A conflict is flagged when both ports write the same address that actually gets stored.
  always_comb begin
    conflict_d = (state_q == ST_RUN) && r_wr_en_a && r_wr_en_b &&
                 (r_addr_in_a == r_addr_in_b) && !zero_a;
  end

  // Control FSM: the INIT sweep counter, the ready flag and the registered conflict pulse.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples values from before the clock edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          conflict_q <= 1'b0;
          if (cnt_q == '1) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          conflict_q <= conflict_d;
        end
      endcase
    end
  end

  // Array update: the sweep writes during INIT, and ports A then B write during RUN (B wins).
  // NOTE: the storage array has no reset. Only the post-reset sweep
  // initialises it, so it maps onto plain RAM or flops without a reset.
  always_ff @(posedge r_clk) begin
    if (state_q == ST_INIT) begin
      data_reg[cnt_q] <= init_val;
    end else begin
      if (wr_a_ok) data_reg[r_addr_in_a] <= r_data_in_a;
      if (wr_b_ok) data_reg[r_addr_in_b] <= r_data_in_b;
    end
  end

  logic [AWIDTH-1:0] rd_addr [2];
  assign rd_addr[0] = r_addr_out1;
  assign rd_addr[1] = r_addr_out2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DWIDTH-1:0] data;

    // Read mux in priority order: zero register, bypass from B, bypass from A, then the array.
    always_comb begin
      data = '0;
      if (state_q == ST_RUN) begin
        if ((ZERO_REG != 0) && (rd_addr[p] == '0))           data = '0;
        else if (r_wr_en_b && (r_addr_in_b == rd_addr[p]))   data = r_data_in_b;
        else if (r_wr_en_a && (r_addr_in_a == rd_addr[p]))   data = r_data_in_a;
        else                                                 data = data_reg[rd_addr[p]];
      end
    end
  end

  assign r_data_out1   = g_rd[0].data;
  assign r_data_out2   = g_rd[1].data;
  assign r_ready       = ready_q;
  assign r_wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_dual_wr.sv
// Directed testbench for regfile_dual_wr with the default parameters
// (DWIDTH=32, AWIDTH=5, INIT_MODE=1, ZERO_REG=1).
module tb_regfile_dual_wr;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b0;
  logic        r_wr_en_a = 1'b0;
  logic [4:0]  r_addr_in_a = '0;
  logic [31:0] r_data_in_a = '0;
  logic        r_wr_en_b = 1'b0;
  logic [4:0]  r_addr_in_b = '0;
  logic [31:0] r_data_in_b = '0;
  logic [4:0]  r_addr_out1 = '0;
  logic [4:0]  r_addr_out2 = '0;
  logic [31:0] r_data_out1;
  logic [31:0] r_data_out2;
  logic        r_ready;
  logic        r_wr_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_dual_wr dut (
    .r_clk         (r_clk),
    .r_rst         (r_rst),
    .r_wr_en_a     (r_wr_en_a),
    .r_addr_in_a   (r_addr_in_a),
    .r_data_in_a   (r_data_in_a),
    .r_wr_en_b     (r_wr_en_b),
    .r_addr_in_b   (r_addr_in_b),
    .r_data_in_b   (r_data_in_b),
    .r_addr_out1   (r_addr_out1),
    .r_addr_out2   (r_addr_out2),
    .r_data_out1   (r_data_out1),
    .r_data_out2   (r_data_out2),
    .r_ready       (r_ready),
    .r_wr_conflict (r_wr_conflict)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count the rising edges until r_ready is set (-1 if the bound expires).
  // Optionally attempts a port-A write to addr 4 partway through INIT.
  task automatic wait_ready(input bit init_write, output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge r_clk);
      #1;
      if (r_ready) begin
        edges = i;
        break;
      end
      if (init_write && i == 10) begin
        r_wr_en_a   = 1'b1;
        r_addr_in_a = 5'd4;
        r_data_in_a = 32'h0000ABCD;
        r_addr_out1 = 5'd4;
        r_addr_out2 = 5'd7;
        #1;
        check("init_no_bypass_out1", r_data_out1, 32'h0);
        check("init_out2_zero", r_data_out2, 32'h0);
      end
      if (init_write && i == 11) begin
        r_wr_en_a = 1'b0;
        check("init_no_conflict", {31'b0, r_wr_conflict}, 32'h0);
      end
    end
  endtask

  int edges;

  initial begin
    // Reset state
    repeat (3) @(posedge r_clk);
    #1;
    check("rst_ready", {31'b0, r_ready}, 32'h0);
    check("rst_conflict", {31'b0, r_wr_conflict}, 32'h0);
    check("rst_out1", r_data_out1, 32'h0);

    // First sweep with an ignored write issued during INIT
    @(negedge r_clk);
    r_rst = 1'b1;
    wait_ready(1'b1, edges);
    check("sweep1_edges", edges, 32'd32);

    r_addr_out1 = 5'd7;
    r_addr_out2 = 5'd31;
    #1;
    check("init_entry7", r_data_out1, 32'd7);
    check("init_entry31", r_data_out2, 32'd31);
    r_addr_out1 = 5'd0;
    r_addr_out2 = 5'd4;
    #1;
    check("entry0_zero", r_data_out1, 32'h0);
    check("init_write_ignored", r_data_out2, 32'd4);

    // Same-cycle bypass on port A, followed by the stored value
    r_wr_en_a   = 1'b1;
    r_addr_in_a = 5'd5;
    r_data_in_a = 32'hDEADBEEF;
    r_addr_out1 = 5'd5;
    #1;
    check("bypass_a", r_data_out1, 32'hDEADBEEF);
    @(posedge r_clk);
    #1;
    r_wr_en_a = 1'b0;
    #1;
    check("stored_a", r_data_out1, 32'hDEADBEEF);
    check("single_wr_no_conflict", {31'b0, r_wr_conflict}, 32'h0);

    // Both ports write the same address: B wins and the conflict pulse follows
    r_wr_en_a   = 1'b1;
    r_addr_in_a = 5'd9;
    r_data_in_a = 32'h11;
    r_wr_en_b   = 1'b1;
    r_addr_in_b = 5'd9;
    r_data_in_b = 32'h22;
    r_addr_out2 = 5'd9;
    #1;
    check("bypass_b_wins", r_data_out2, 32'h22);
    @(posedge r_clk);
    #1;
    r_wr_en_a = 1'b0;
    r_wr_en_b = 1'b0;
    r_addr_out1 = 5'd9;
    #1;
    check("conflict_pulse", {31'b0, r_wr_conflict}, 32'h1);
    check("stored_b_wins", r_data_out2, 32'h22);
    check("same_addr_both_ports", r_data_out1, 32'h22);
    @(posedge r_clk);
    #1;
    check("conflict_one_cycle", {31'b0, r_wr_conflict}, 32'h0);

    // Both ports write different addresses in the same cycle
    r_wr_en_a   = 1'b1;
    r_addr_in_a = 5'd12;
    r_data_in_a = 32'hA5A5A5A5;
    r_wr_en_b   = 1'b1;
    r_addr_in_b = 5'd13;
    r_data_in_b = 32'h5A5A5A5A;
    r_addr_out1 = 5'd12;
    r_addr_out2 = 5'd13;
    @(posedge r_clk);
    #1;
    r_wr_en_a = 1'b0;
    r_wr_en_b = 1'b0;
    #1;
    check("dual_wr_a", r_data_out1, 32'hA5A5A5A5);
    check("dual_wr_b", r_data_out2, 32'h5A5A5A5A);
    check("diff_addr_no_conflict", {31'b0, r_wr_conflict}, 32'h0);

    // Writes to address 0 are dropped and do not flag a conflict
    r_wr_en_a   = 1'b1;
    r_addr_in_a = 5'd0;
    r_data_in_a = 32'hFFFFFFFF;
    r_wr_en_b   = 1'b1;
    r_addr_in_b = 5'd0;
    r_data_in_b = 32'h1234;
    r_addr_out1 = 5'd0;
    #1;
    check("zero_reg_during", r_data_out1, 32'h0);
    @(posedge r_clk);
    #1;
    r_wr_en_a = 1'b0;
    r_wr_en_b = 1'b0;
    #1;
    check("zero_reg_after", r_data_out1, 32'h0);
    check("zero_reg_no_conflict", {31'b0, r_wr_conflict}, 32'h0);

    // Reset while in RUN: ready drops immediately
    r_rst = 1'b0;
    #1;
    check("rst_run_ready", {31'b0, r_ready}, 32'h0);
    check("rst_run_out_zero", r_data_out1, 32'h0);
    @(negedge r_clk);
    r_rst = 1'b1;

    // Reset again after 10 sweep cycles; the sweep restarts from entry 0
    repeat (10) @(posedge r_clk);
    #1;
    r_rst = 1'b0;
    #1;
    check("rst_mid_init_ready", {31'b0, r_ready}, 32'h0);
    @(negedge r_clk);
    r_rst = 1'b1;
    wait_ready(1'b0, edges);
    check("sweep2_edges", edges, 32'd32);
    r_addr_out1 = 5'd3;
    r_addr_out2 = 5'd9;
    #1;
    check("resweep_entry3", r_data_out1, 32'd3);
    check("resweep_entry9", r_data_out2, 32'd9);
    r_addr_out1 = 5'd5;
    #1;
    check("resweep_entry5", r_data_out1, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
